cp0_vic: RTL and testbench

- Vectored, multi-channel successor to the single-line CP0 interrupt unit.
- Sits beside the 5-stage core and serves MFC0/MTC0/ERET from the pipeline.
- Latches N_IRQ external requests with per-channel edge/level mode and masking, picks the highest-priority request, and forces a jump to a per-channel vector.
- Saves the return PC and restores it on ERET.

---
 rtl/cp0_vic_pkg.sv | 28 ++
 rtl/irq_sync_edge.sv | 33 +++
 rtl/cp0_vic.sv | 154 +++++++++++++++
 tb/tb_cp0_vic.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_vic_pkg.sv
// Shared encodings for the vectored CP0 interrupt controller:
// pipeline operation codes, register addresses and STATUS bit positions.
package cp0_vic_pkg;

    localparam int unsigned OPER_W  = 2;
    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned CAUSE_W = 4;

    typedef enum logic [OPER_W-1:0] {
        OPER_NONE = 2'd0,
        OPER_MFC0 = 2'd1,
        OPER_MTC0 = 2'd2,
        OPER_ERET = 2'd3
    } oper_e;

    localparam logic [ADDR_W-1:0] REG_STATUS  = 5'd0;
    localparam logic [ADDR_W-1:0] REG_MASK    = 5'd1;
    localparam logic [ADDR_W-1:0] REG_MODE    = 5'd2;
    localparam logic [ADDR_W-1:0] REG_PENDING = 5'd3;
    localparam logic [ADDR_W-1:0] REG_EPC     = 5'd4;
    localparam logic [ADDR_W-1:0] REG_CAUSE   = 5'd5;
    localparam logic [ADDR_W-1:0] REG_BASE    = 5'd6;

    localparam int unsigned ST_IE  = 0;
    localparam int unsigned ST_EXL = 1;

endpackage

// File: rtl/irq_sync_edge.sv
// One interrupt line: multi-flop synchronizer followed by a rising-edge
// detector on the synchronized level.
module irq_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Zeroed history makes a line held high through reset look like a fresh edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q[0] <= d;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level  = sync_q[SYNC_STAGES-1];
    assign rise_c = level & ~prev_q;

endmodule

// File: rtl/cp0_vic.sv
// Vectored multi-channel CP0 interrupt controller: coprocessor register file,
// fixed-priority arbitration, and take/ERET forced-jump generation.
module cp0_vic
    import cp0_vic_pkg::*;
#(
    parameter int unsigned       N_IRQ       = 4,
    parameter int unsigned       SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] VEC_BASE    = 32'h0000_0020,
    parameter int unsigned       VEC_SHIFT   = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPER_W-1:0]   oper,
    input  logic [ADDR_W-1:0]   addr_r,
    output logic [DATA_W-1:0]   data_r,
    input  logic [ADDR_W-1:0]   addr_w,
    input  logic [DATA_W-1:0]   data_w,
    input  logic [N_IRQ-1:0]    ir_in,
    input  logic                ir_en,
    input  logic [DATA_W-1:0]   ret_addr,
    output logic                ir,
    output logic                ir_valid,
    output logic                ir_wait,
    output logic [CAUSE_W-1:0]  ir_cause,
    output logic                jump_en,
    output logic [DATA_W-1:0]   jump_addr
);

    // Lowest set index wins; channel 0 has the highest priority.
    function automatic logic [CAUSE_W-1:0] prio_enc(input logic [N_IRQ-1:0] v);
        logic [CAUSE_W-1:0] idx;
        idx = '0;
        for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
            if (v[i]) idx = CAUSE_W'(i);
        end
        return idx;
    endfunction

    logic [N_IRQ-1:0] sync_lvl;
    logic [N_IRQ-1:0] sync_rise;

    for (genvar g = 0; g < N_IRQ; g++) begin : g_sync
        irq_sync_edge #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk    (clk),
            .rst    (rst),
            .d      (ir_in[g]),
            .level  (sync_lvl[g]),
            .rise_c (sync_rise[g])
        );
    end

    logic                ie_q;
    logic                exl_q;
    logic [N_IRQ-1:0]    mask_q;
    logic [N_IRQ-1:0]    mode_q;
    logic [N_IRQ-1:0]    pend_q;
    logic [DATA_W-1:0]   epc_q;
    logic [DATA_W-1:0]   base_q;
    logic [CAUSE_W-1:0]  cause_q;

    logic [N_IRQ-1:0]    pending_c;
    logic [N_IRQ-1:0]    req_c;
    logic [N_IRQ-1:0]    w1c_c;
    logic [N_IRQ-1:0]    take_clr_c;
    logic [N_IRQ-1:0]    pend_d_c;
    logic [CAUSE_W-1:0]  sel_c;
    logic                is_mtc0_c;
    logic                is_eret_c;
    logic                take_c;

    // Edge channels use the latched bit; level channels follow the synchronized line.
    assign pending_c  = (mode_q & pend_q) | (~mode_q & sync_lvl);
    assign req_c      = pending_c & mask_q;
    assign sel_c      = prio_enc(req_c);
    assign ir_valid   = ie_q & (|req_c);
    assign ir_wait    = ir_valid & (exl_q | ~ir_en);

    assign is_mtc0_c  = (oper == OPER_MTC0);
    assign is_eret_c  = (oper == OPER_ERET);
    assign take_c     = ir_valid & ~exl_q & ir_en & ~is_eret_c;

    assign w1c_c      = (is_mtc0_c && addr_w == REG_PENDING) ? data_w[N_IRQ-1:0] : '0;
    assign take_clr_c = take_c ? (N_IRQ'(1) << sel_c) : '0;
    // A new edge beats any clear in the same cycle.
    assign pend_d_c   = mode_q & ((pend_q & ~(w1c_c | take_clr_c)) | sync_rise);

    always_comb begin
        data_r = '0;
        case (addr_r)
            REG_STATUS: begin
                data_r[ST_IE]  = ie_q;
                data_r[ST_EXL] = exl_q;
            end
            REG_MASK:    data_r = DATA_W'(mask_q);
            REG_MODE:    data_r = DATA_W'(mode_q);
            REG_PENDING: data_r = DATA_W'(pending_c);
            REG_EPC:     data_r = epc_q;
            REG_CAUSE:   data_r = DATA_W'(cause_q);
            REG_BASE:    data_r = base_q;
            default:     data_r = '0;
        endcase
    end

    // Register file plus jump generation; take beats MTC0, ERET beats take.
    always_ff @(posedge clk) begin
        if (rst) begin
            ie_q      <= 1'b0;
            exl_q     <= 1'b0;
            mask_q    <= '0;
            mode_q    <= '0;
            pend_q    <= '0;
            epc_q     <= '0;
            base_q    <= VEC_BASE;
            cause_q   <= '0;
            ir_cause  <= '0;
            jump_en   <= 1'b0;
            ir        <= 1'b0;
            jump_addr <= '0;
        end else begin
            pend_q  <= pend_d_c;
            jump_en <= 1'b0;
            ir      <= 1'b0;

            if (is_mtc0_c) begin
                case (addr_w)
                    REG_STATUS: ie_q    <= data_w[ST_IE];
                    REG_MASK:   mask_q  <= data_w[N_IRQ-1:0];
                    REG_MODE:   mode_q  <= data_w[N_IRQ-1:0];
                    REG_EPC:    epc_q   <= data_w;
                    REG_CAUSE:  cause_q <= data_w[CAUSE_W-1:0];
                    REG_BASE:   base_q  <= data_w;
                    default: ;
                endcase
            end

            if (take_c) begin
                epc_q     <= ret_addr;
                cause_q   <= sel_c;
                ir_cause  <= sel_c;
                exl_q     <= 1'b1;
                jump_en   <= 1'b1;
                ir        <= 1'b1;
                jump_addr <= base_q + (DATA_W'(sel_c) << VEC_SHIFT);
            end else if (is_eret_c) begin
                exl_q     <= 1'b0;
                jump_en   <= 1'b1;
                jump_addr <= epc_q;
            end
        end
    end

endmodule

// File: tb/tb_cp0_vic.sv
// Bench for cp0_vic: directed scenarios plus randomized traffic, all checked
// cycle by cycle against a behavioural model of the controller.
module tb_cp0_vic;

    localparam int unsigned N  = 4;
    localparam int unsigned SS = 2;
    localparam int unsigned VS = 3;
    localparam logic [31:0] VB = 32'h0000_0020;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    oper;
    logic [4:0]    addr_r;
    logic [31:0]   data_r;
    logic [4:0]    addr_w;
    logic [31:0]   data_w;
    logic [N-1:0]  ir_in;
    logic          ir_en;
    logic [31:0]   ret_addr;
    logic          ir;
    logic          ir_valid;
    logic          ir_wait;
    logic [3:0]    ir_cause;
    logic          jump_en;
    logic [31:0]   jump_addr;

    cp0_vic #(
        .N_IRQ       (N),
        .SYNC_STAGES (SS),
        .VEC_BASE    (VB),
        .VEC_SHIFT   (VS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .oper      (oper),
        .addr_r    (addr_r),
        .data_r    (data_r),
        .addr_w    (addr_w),
        .data_w    (data_w),
        .ir_in     (ir_in),
        .ir_en     (ir_en),
        .ret_addr  (ret_addr),
        .ir        (ir),
        .ir_valid  (ir_valid),
        .ir_wait   (ir_wait),
        .ir_cause  (ir_cause),
        .jump_en   (jump_en),
        .jump_addr (jump_addr)
    );

    always #25 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Architectural model state.
    logic          m_ie, m_exl;
    logic [N-1:0]  m_mask, m_mode, m_pend;
    logic [31:0]   m_epc, m_base, m_jump_addr;
    logic [3:0]    m_cause, m_ir_cause;
    logic          m_jump_en, m_ir;
    logic [N-1:0]  hist [0:SS];  // hist[k] = ir_in sampled k+1 edges ago

    task automatic model_reset();
        m_ie = 1'b0; m_exl = 1'b0;
        m_mask = '0; m_mode = '0; m_pend = '0;
        m_epc = '0; m_base = VB; m_cause = '0; m_ir_cause = '0;
        m_jump_en = 1'b0; m_ir = 1'b0; m_jump_addr = '0;
        for (int k = 0; k <= int'(SS); k++) hist[k] = '0;
    endtask

    function automatic int first_set(input logic [N-1:0] v);
        for (int i = 0; i < int'(N); i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a, input logic [N-1:0] pend);
        logic [31:0] v;
        v = '0;
        case (a)
            5'd0: begin v[0] = m_ie; v[1] = m_exl; end
            5'd1: v[N-1:0] = m_mask;
            5'd2: v[N-1:0] = m_mode;
            5'd3: v[N-1:0] = pend;
            5'd4: v = m_epc;
            5'd5: v[3:0] = m_cause;
            5'd6: v = m_base;
            default: v = '0;
        endcase
        return v;
    endfunction

    // One clock: compare combinational outputs, advance the model across the
    // edge, compare registered outputs. Entered and left at a falling edge.
    task automatic step();
        logic [N-1:0] s, s_prev, rise, pend, req;
        logic [31:0]  old_base, old_epc;
        logic [N-1:0] old_mode;
        int           sel;
        bit           valid, take;
        #1;
        s      = hist[SS-1];
        s_prev = hist[SS];
        rise   = s & ~s_prev;
        pend   = m_pend;
        for (int i = 0; i < int'(N); i++) if (!m_mode[i]) pend[i] = s[i];
        req    = pend & m_mask;
        sel    = first_set(req);
        valid  = m_ie && (req != '0);
        check("data_r", data_r, model_read(addr_r, pend));
        check("ir_valid", 32'(ir_valid), 32'(valid));
        check("ir_wait", 32'(ir_wait), 32'(valid && (m_exl || !ir_en)));
        take = valid && !m_exl && ir_en && (oper != 2'd3);

        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else begin
            old_base = m_base;
            old_epc  = m_epc;
            old_mode = m_mode;
            m_jump_en = 1'b0;
            m_ir      = 1'b0;
            for (int i = 0; i < int'(N); i++) begin
                if (!old_mode[i])                                   m_pend[i] = 1'b0;
                else if (rise[i])                                   m_pend[i] = 1'b1;
                else if (oper == 2'd2 && addr_w == 5'd3 && data_w[i]) m_pend[i] = 1'b0;
                else if (take && sel == i)                          m_pend[i] = 1'b0;
            end
            if (oper == 2'd2) begin
                case (addr_w)
                    5'd0: m_ie    = data_w[0];
                    5'd1: m_mask  = data_w[N-1:0];
                    5'd2: m_mode  = data_w[N-1:0];
                    5'd4: m_epc   = data_w;
                    5'd5: m_cause = data_w[3:0];
                    5'd6: m_base  = data_w;
                    default: ;
                endcase
            end
            if (take) begin
                m_epc       = ret_addr;
                m_cause     = 4'(sel);
                m_ir_cause  = 4'(sel);
                m_exl       = 1'b1;
                m_jump_en   = 1'b1;
                m_ir        = 1'b1;
                m_jump_addr = old_base + 32'(sel * (1 << VS));
            end else if (oper == 2'd3) begin
                m_exl       = 1'b0;
                m_jump_en   = 1'b1;
                m_jump_addr = old_epc;
            end
            for (int k = int'(SS); k > 0; k--) hist[k] = hist[k-1];
            hist[0] = ir_in;
        end
        check("jump_en", 32'(jump_en), 32'(m_jump_en));
        check("ir", 32'(ir), 32'(m_ir));
        check("jump_addr", jump_addr, m_jump_addr);
        check("ir_cause", 32'(ir_cause), 32'(m_ir_cause));
        @(negedge clk);
    endtask

    task automatic rd_check(input string tag, input logic [4:0] a, input logic [31:0] exp);
        addr_r = a;
        #1;
        check(tag, data_r, exp);
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        oper = 2'd2; addr_w = a; data_w = d;
        step();
        oper = 2'd0;
    endtask

    task automatic eret();
        oper = 2'd3;
        step();
        oper = 2'd0;
    endtask

    initial begin
        rst = 1'b1; oper = 2'd0; addr_r = '0; addr_w = '0; data_w = '0;
        ir_in = '0; ir_en = 1'b0; ret_addr = '0;
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Reset state.
        rd_check("rst_status", 5'd0, 32'h0);
        rd_check("rst_mask", 5'd1, 32'h0);
        rd_check("rst_mode", 5'd2, 32'h0);
        rd_check("rst_pending", 5'd3, 32'h0);
        rd_check("rst_epc", 5'd4, 32'h0);
        rd_check("rst_base", 5'd6, 32'h20);
        rd_check("rst_addr7", 5'd7, 32'h0);
        check("rst_jump_en", 32'(jump_en), 32'h0);
        check("rst_ir_valid", 32'(ir_valid), 32'h0);

        // Single edge on channel 2: jump three edges after the sampling edge.
        ir_en = 1'b1; ret_addr = 32'h100;
        mtc0(5'd1, 32'hF); mtc0(5'd2, 32'hF); mtc0(5'd0, 32'h1);
        ir_in = 4'b0100; step(); ir_in = '0;
        step(); check("t2_early1", 32'(jump_en), 32'h0);
        step(); check("t2_early2", 32'(jump_en), 32'h0);
        step();
        check("t2_jump_en", 32'(jump_en), 32'h1);
        check("t2_ir", 32'(ir), 32'h1);
        check("t2_addr", jump_addr, 32'h30);
        step(); check("t2_pulse", 32'(jump_en), 32'h0);
        rd_check("t2_epc", 5'd4, 32'h100);
        rd_check("t2_cause", 5'd5, 32'h2);
        rd_check("t2_status", 5'd0, 32'h3);
        rd_check("t2_pending", 5'd3, 32'h0);

        // Simultaneous edges on 1 and 3, then tail-chain after ERET.
        eret();
        check("t3_eret0", 32'(jump_en), 32'h1);
        ir_in = 4'b1010; step(); ir_in = '0;
        repeat (3) step();
        check("t3_ch1_addr", jump_addr, 32'h28);
        check("t3_ch1_cause", 32'(ir_cause), 32'h1);
        rd_check("t3_pending", 5'd3, 32'h8);
        check("t3_wait", 32'(ir_wait), 32'h1);
        eret();
        check("t3_eret_en", 32'(jump_en), 32'h1);
        check("t3_eret_ir", 32'(ir), 32'h0);
        check("t3_eret_addr", jump_addr, 32'h100);
        step();
        check("t3_ch3_en", 32'(jump_en), 32'h1);
        check("t3_ch3_addr", jump_addr, 32'h38);
        eret();

        // Blocked by ir_en, then released.
        ir_en = 1'b0;
        ir_in = 4'b0001; step(); ir_in = '0;
        repeat (2) step();
        repeat (5) begin
            step();
            check("t4_nojump", 32'(jump_en), 32'h0);
            check("t4_wait", 32'(ir_wait), 32'h1);
        end
        ir_en = 1'b1; step();
        check("t4_release", 32'(jump_en), 32'h1);
        check("t4_addr", jump_addr, 32'h20);
        eret();

        // W1C colliding with a fresh edge on the same channel.
        ir_en = 1'b0;
        ir_in = 4'b0100; step(); ir_in = '0;
        repeat (2) step();
        ir_in = 4'b0100; step(); ir_in = '0;
        step();
        mtc0(5'd3, 32'h4);
        rd_check("t4_set_wins", 5'd3, 32'h4);
        mtc0(5'd3, 32'h4);
        rd_check("t4_w1c", 5'd3, 32'h0);

        // Level channel 0: masked, unmasked, retaken after ERET.
        mtc0(5'd2, 32'hE); mtc0(5'd1, 32'hE);
        ir_en = 1'b1; ir_in = 4'b0001;
        repeat (4) step();
        check("t5_masked", 32'(ir_valid), 32'h0);
        mtc0(5'd1, 32'hF);
        step();
        check("t5_take", 32'(jump_en), 32'h1);
        check("t5_addr", jump_addr, 32'h20);
        eret();
        check("t5_eret_ir", 32'(ir), 32'h0);
        step();
        check("t5_retake", 32'(ir), 32'h1);
        check("t5_retake_addr", jump_addr, 32'h20);

        // Reset in the cycle a take condition holds.
        eret();
        rst = 1'b1; step(); rst = 1'b0;
        check("t6_no_jump", 32'(jump_en), 32'h0);
        rd_check("t6_status", 5'd0, 32'h0);
        rd_check("t6_epc", 5'd4, 32'h0);
        rd_check("t6_pending", 5'd3, 32'h0);
        ir_in = '0;

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            oper     = (r < 6) ? 2'd0 : (r == 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            addr_w   = 5'($urandom_range(0, 7));
            data_w   = $urandom;
            addr_r   = 5'($urandom_range(0, 9));
            ret_addr = $urandom;
            ir_en    = ($urandom_range(0, 3) != 0);
            rst      = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < int'(N); i++) begin
                if ($urandom_range(0, 5) == 0) ir_in[i] = ~ir_in[i];
            end
            step();
        end
        rst = 1'b0; oper = 2'd0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
